// File: rtl/fwd_hazard_unit.sv
// Operand bypass select and long-latency load-use hazard scoreboard.
// fwd_sel picks the youngest bypass stage that writes each EX source.
// A small scoreboard tracks long-latency results still in flight and
// holds ID while any ID source depends on one of them.
module fwd_hazard_unit #(
   parameter int NUM_SRC    = 2,
   parameter int NUM_STAGES = 2,
   parameter int AW         = 5,
   parameter int NUM_PEND   = 4,
   parameter int MAX_LAT    = 4,
   localparam int LAT_W     = $clog2(MAX_LAT + 1),
   localparam int SEL_W     = $clog2(NUM_STAGES + 1)
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NUM_SRC*AW-1:0]     id_rs,
   input  logic [NUM_SRC*AW-1:0]     ex_rs,
   input  logic [NUM_STAGES*AW-1:0]  stg_rd,
   input  logic [NUM_STAGES-1:0]     stg_regwrite,
   input  logic                      issue_valid,
   input  logic                      issue_longlat,
   input  logic [AW-1:0]             issue_rd,
   input  logic [LAT_W-1:0]          issue_lat,
   input  logic                      flush,
   output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
   output logic                      stall,
   output logic                      pend_full,
   output logic [15:0]               stall_cycles
);

   localparam int IDX_W = (NUM_PEND > 1) ? $clog2(NUM_PEND) : 1;

   logic [NUM_PEND-1:0] valid_q, valid_d;
   logic [AW-1:0]       rd_q  [NUM_PEND];
   logic [AW-1:0]       rd_d  [NUM_PEND];
   logic [LAT_W-1:0]    cnt_q [NUM_PEND];
   logic [LAT_W-1:0]    cnt_d [NUM_PEND];
   logic [15:0]         stall_cnt_q;

   logic                raw_hit;
   logic                issue_ok;
   logic [LAT_W-1:0]    lat_sat;
   logic                waw_hit;
   logic [IDX_W-1:0]    waw_idx;
   logic                free_found;
   logic [IDX_W-1:0]    free_idx;

   // Bypass select: scan oldest to youngest so the youngest match wins.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
      fwd_sel = '0;
      for (int s = 0; s < NUM_SRC; s++) begin
         fwd_sel[s*SEL_W +: SEL_W] = SEL_W'(NUM_STAGES);
         for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            if (stg_regwrite[k] && (ex_rs[s*AW +: AW] != '0) &&
                (stg_rd[k*AW +: AW] == ex_rs[s*AW +: AW])) begin
               fwd_sel[s*SEL_W +: SEL_W] = SEL_W'(k);
            end
         end
      end
   end

   // RAW check of ID sources against results still in flight.
   always_comb begin
      raw_hit = 1'b0;
      for (int s = 0; s < NUM_SRC; s++) begin
         for (int e = 0; e < NUM_PEND; e++) begin
            if (valid_q[e] && (id_rs[s*AW +: AW] != '0) &&
                (rd_q[e] == id_rs[s*AW +: AW])) begin
               raw_hit = 1'b1;
            end
         end
      end
   end

   assign pend_full    = &valid_q;
   assign stall        = raw_hit | (pend_full & issue_valid & issue_longlat);
   assign issue_ok     = issue_valid & issue_longlat & ~stall &
                         (issue_rd != '0) & (issue_lat != '0);
   assign lat_sat      = (issue_lat > LAT_W'(MAX_LAT)) ? LAT_W'(MAX_LAT) : issue_lat;
   assign stall_cycles = stall_cnt_q;

   // Scoreboard next state: countdown, then WAW overwrite or allocation, flush last.
   always_comb begin
      // NOTE: blocking assignments here; later statements deliberately override earlier ones within the same evaluation.
      valid_d    = valid_q;
      rd_d       = rd_q;
      cnt_d      = cnt_q;
      waw_hit    = 1'b0;
      waw_idx    = '0;
      free_found = 1'b0;
      free_idx   = '0;

      for (int e = 0; e < NUM_PEND; e++) begin
         if (valid_q[e]) begin
            cnt_d[e] = cnt_q[e] - 1'b1;
            if (cnt_q[e] == LAT_W'(1)) begin
               valid_d[e] = 1'b0;
            end
         end
         if (valid_q[e] && (rd_q[e] == issue_rd)) begin
            waw_hit = 1'b1;
            waw_idx = IDX_W'(e);
         end
      end

      // Free slots come from the current valid bits, so an entry retiring
      // this cycle is not handed out until the next one.
      for (int e = NUM_PEND - 1; e >= 0; e--) begin
         if (!valid_q[e]) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(e);
         end
      end

      if (flush) begin
         valid_d = '0;
      end else if (issue_ok) begin
         if (waw_hit) begin
            valid_d[waw_idx] = 1'b1;
            cnt_d[waw_idx]   = lat_sat;
         end else if (free_found) begin
            valid_d[free_idx] = 1'b1;
            rd_d[free_idx]    = issue_rd;
            cnt_d[free_idx]   = lat_sat;
         end
      end
   end

   // Scoreboard state and saturating stall counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q     <= '0;
         stall_cnt_q <= '0;
         // NOTE: the entry array is small, so it is reset outright; a large RAM would only reset its valid bits.
         for (int e = 0; e < NUM_PEND; e++) begin
            rd_q[e]  <= '0;
            cnt_q[e] <= '0;
         end
      end else begin
         // NOTE: non-blocking assignments for all flops so every register samples pre-edge values.
         valid_q <= valid_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
         if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: a bypass-select vector table
// plus hand-written scoreboard sequences.
module tb_fwd_hazard_unit;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [9:0]  id_rs = '0;
   logic [9:0]  ex_rs = '0;
   logic [9:0]  stg_rd = '0;
   logic [1:0]  stg_regwrite = '0;
   logic        issue_valid = 1'b0;
   logic        issue_longlat = 1'b0;
   logic [4:0]  issue_rd = '0;
   logic [2:0]  issue_lat = '0;
   logic        flush = 1'b0;
   logic [3:0]  fwd_sel;
   logic        stall;
   logic        pend_full;
   logic [15:0] stall_cycles;

   // Three-source, three-stage instance for the bypass select only.
   logic [14:0] id_rs3 = '0;
   logic [14:0] ex_rs3 = '0;
   logic [14:0] stg_rd3 = '0;
   logic [2:0]  stg_regwrite3 = '0;
   logic [5:0]  fwd_sel3;
   logic        stall3;
   logic        pend_full3;
   logic [15:0] stall_cycles3;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   fwd_hazard_unit u_dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .id_rs        (id_rs),
      .ex_rs        (ex_rs),
      .stg_rd       (stg_rd),
      .stg_regwrite (stg_regwrite),
      .issue_valid  (issue_valid),
      .issue_longlat(issue_longlat),
      .issue_rd     (issue_rd),
      .issue_lat    (issue_lat),
      .flush        (flush),
      .fwd_sel      (fwd_sel),
      .stall        (stall),
      .pend_full    (pend_full),
      .stall_cycles (stall_cycles)
   );

   fwd_hazard_unit #(.NUM_SRC(3), .NUM_STAGES(3)) u_dut3 (
      .clk          (clk),
      .reset_n      (reset_n),
      .id_rs        (id_rs3),
      .ex_rs        (ex_rs3),
      .stg_rd       (stg_rd3),
      .stg_regwrite (stg_regwrite3),
      .issue_valid  (1'b0),
      .issue_longlat(1'b0),
      .issue_rd     (5'd0),
      .issue_lat    (3'd0),
      .flush        (1'b0),
      .fwd_sel      (fwd_sel3),
      .stall        (stall3),
      .pend_full    (pend_full3),
      .stall_cycles (stall_cycles3)
   );

   typedef struct {
      string      name;
      logic [9:0] ex_rs;
      logic [9:0] stg_rd;
      logic [1:0] we;
      logic [3:0] exp_sel;
   } fvec_t;

   fvec_t fv [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      issue_valid   = 1'b0;
      issue_longlat = 1'b0;
      issue_rd      = '0;
      issue_lat     = '0;
      flush         = 1'b0;
      id_rs         = '0;
   endtask

   task automatic issue(input logic [4:0] rd, input logic [2:0] lat);
      issue_valid   = 1'b1;
      issue_longlat = 1'b1;
      issue_rd      = rd;
      issue_lat     = lat;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      idle();
      #2;
      reset_n = 1'b1;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // Bypass table: {slot1, slot0} packing, stage k at [k*5 +: 5].
      fv[0] = '{"byp_both_we",  {5'd0, 5'd5},   {5'd5, 5'd5},   2'b11, {2'd2, 2'd0}};
      fv[1] = '{"byp_old_only", {5'd0, 5'd5},   {5'd5, 5'd5},   2'b10, {2'd2, 2'd1}};
      fv[2] = '{"byp_x0",       {5'd0, 5'd0},   {5'd5, 5'd5},   2'b11, {2'd2, 2'd2}};
      fv[3] = '{"byp_no_we",    {5'd5, 5'd5},   {5'd5, 5'd5},   2'b00, {2'd2, 2'd2}};
      fv[4] = '{"byp_split",    {5'd3, 5'd5},   {5'd3, 5'd5},   2'b11, {2'd1, 2'd0}};
      fv[5] = '{"byp_nomatch",  {5'd7, 5'd6},   {5'd3, 5'd5},   2'b11, {2'd2, 2'd2}};
      fv[6] = '{"byp_rd_zero",  {5'd0, 5'd0},   {5'd0, 5'd0},   2'b11, {2'd2, 2'd2}};
      fv[7] = '{"byp_r31",      {5'd31, 5'd31}, {5'd31, 5'd4},  2'b11, {2'd1, 2'd1}};

      // Reset state
      #1;
      check("rst_stall", {31'd0, stall}, 32'd0);
      check("rst_full", {31'd0, pend_full}, 32'd0);
      check("rst_cycles", {16'd0, stall_cycles}, 32'd0);
      #3;
      reset_n = 1'b1;
      tick();

      // Bypass select table
      for (int i = 0; i < 8; i++) begin
         ex_rs        = fv[i].ex_rs;
         stg_rd       = fv[i].stg_rd;
         stg_regwrite = fv[i].we;
         #1;
         check(fv[i].name, {28'd0, fwd_sel}, {28'd0, fv[i].exp_sel});
      end

      // Three-stage, three-source instance
      ex_rs3 = {5'd0, 5'd0, 5'd9};
      stg_rd3 = {5'd9, 5'd4, 5'd6};
      stg_regwrite3 = 3'b111;
      #1;
      check("p3_stage2", {26'd0, fwd_sel3}, {26'd0, 2'd3, 2'd3, 2'd2});
      stg_rd3 = {5'd8, 5'd4, 5'd6};
      #1;
      check("p3_nomatch", {26'd0, fwd_sel3}, {26'd0, 2'd3, 2'd3, 2'd3});
      stg_rd3 = {5'd9, 5'd9, 5'd6};
      #1;
      check("p3_stage1_wins", {26'd0, fwd_sel3}, {26'd0, 2'd3, 2'd3, 2'd1});

      // Load-use: lat=2 -> stall exactly two cycles; issues during stall are dropped
      do_reset();
      issue(5'd7, 3'd2);
      #1;
      check("lu_pre", {31'd0, stall}, 32'd0);
      tick();
      issue(5'd12, 3'd3);
      id_rs = {5'd0, 5'd7};
      #1;
      check("lu_stall1", {31'd0, stall}, 32'd1);
      tick();
      check("lu_stall2", {31'd0, stall}, 32'd1);
      tick();
      check("lu_release", {31'd0, stall}, 32'd0);
      check("lu_cycles", {16'd0, stall_cycles}, 32'd2);
      idle();
      id_rs = {5'd12, 5'd0};
      #1;
      check("lu_dropped_issue", {31'd0, stall}, 32'd0);

      // Latency clamps to MAX_LAT=4
      do_reset();
      issue(5'd8, 3'd7);
      tick();
      idle();
      id_rs = {5'd0, 5'd8};
      #1;
      check("sat_c0", {31'd0, stall}, 32'd1);
      tick();
      tick();
      tick();
      check("sat_c3", {31'd0, stall}, 32'd1);
      tick();
      check("sat_free", {31'd0, stall}, 32'd0);

      // No allocation for rd=0, lat=0 or a short-latency issue
      do_reset();
      issue(5'd0, 3'd3);
      tick();
      issue(5'd6, 3'd0);
      tick();
      issue(5'd11, 3'd3);
      issue_longlat = 1'b0;
      tick();
      idle();
      id_rs = {5'd11, 5'd6};
      #1;
      check("noalloc_stall", {31'd0, stall}, 32'd0);

      // Full scoreboard blocks a long-latency issue until an entry frees
      do_reset();
      for (int i = 1; i <= 4; i++) begin
         issue(5'(i), 3'd4);
         tick();
      end
      issue(5'd5, 3'd4);
      #1;
      check("full_flag", {31'd0, pend_full}, 32'd1);
      check("full_stall", {31'd0, stall}, 32'd1);
      tick();
      check("full_freed", {31'd0, pend_full}, 32'd0);
      check("full_unstall", {31'd0, stall}, 32'd0);
      check("full_cycles", {16'd0, stall_cycles}, 32'd1);
      tick();
      idle();
      id_rs = {5'd0, 5'd5};
      #1;
      check("full_accepted", {31'd0, stall}, 32'd1);

      // WAW: second issue to rd=9 overwrites the countdown
      do_reset();
      issue(5'd9, 3'd4);
      tick();
      issue(5'd9, 3'd2);
      tick();
      idle();
      id_rs = {5'd0, 5'd9};
      #1;
      check("waw_stall1", {31'd0, stall}, 32'd1);
      check("waw_not_full", {31'd0, pend_full}, 32'd0);
      tick();
      check("waw_stall2", {31'd0, stall}, 32'd1);
      tick();
      check("waw_freed", {31'd0, stall}, 32'd0);

      // Flush clears all entries and beats a same-cycle allocation
      do_reset();
      for (int i = 1; i <= 3; i++) begin
         issue(5'(i), 3'd4);
         tick();
      end
      idle();
      id_rs = {5'd0, 5'd1};
      #1;
      check("flush_pre", {31'd0, stall}, 32'd1);
      id_rs = '0;
      issue(5'd4, 3'd4);
      flush = 1'b1;
      tick();
      idle();
      id_rs = {5'd4, 5'd1};
      #1;
      check("flush_full", {31'd0, pend_full}, 32'd0);
      check("flush_stall", {31'd0, stall}, 32'd0);

      // Reset mid-countdown: entries and counter clear at once, fwd_sel stays live
      do_reset();
      issue(5'd7, 3'd4);
      tick();
      idle();
      id_rs = {5'd0, 5'd7};
      tick();
      tick();
      check("mid_cycles", {16'd0, stall_cycles}, 32'd2);
      ex_rs = {5'd0, 5'd5};
      stg_rd = {5'd5, 5'd5};
      stg_regwrite = 2'b10;
      #1;
      reset_n = 1'b0;
      #1;
      check("mid_rst_stall", {31'd0, stall}, 32'd0);
      check("mid_rst_full", {31'd0, pend_full}, 32'd0);
      check("mid_rst_cycles", {16'd0, stall_cycles}, 32'd0);
      check("mid_rst_fwd", {28'd0, fwd_sel}, {28'd0, 2'd2, 2'd1});
      #1;
      reset_n = 1'b1;
      tick();
      check("mid_abandoned", {31'd0, stall}, 32'd0);
      check("mid_cycles_after", {16'd0, stall_cycles}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
